// File: rtl/mine_cover_array.sv
// -----------------------------------------------------------------------------
// mine_cover_array
//   Per-cell cover state for the minesweeper board. Each cell holds 2 bits:
//     2'b00 covered, 2'b01 opened, 2'b10 flagged (2'b11 is never written).
//   Flag/open commands act on the cursor cell (x_pos,y_pos). A newly opened
//   cell produces a one-cycle opened_cell pulse and bumps num_opened. A
//   zero-latency read port serves the display scan at (x_coord,y_coord).
//
// Ports
//   board_clk    in   clock
//   glob_reset   in   asynchronous active-high reset (all cells covered)
//   clear        in   synchronous new-game clear, dominates flag/open
//   flag         in   strobe: toggle flag on cursor cell
//   open         in   strobe: open cursor cell (wins over flag)
//   x_pos/y_pos  in   cursor column/row
//   x_coord/y_coord in read-port column/row
//   cell_val     out  cover state at (x_coord,y_coord), 00 when off-board
//   opened_cell  out  registered pulse, one cycle after a successful open
//   num_opened   out  saturating count of opened cells
// -----------------------------------------------------------------------------
module mine_cover_array #(
  parameter int X_SIZE = 16,
  parameter int Y_SIZE = 16,
  parameter int X_BITS = 4,
  parameter int Y_BITS = 4
) (
  input  logic                     board_clk,
  input  logic                     glob_reset,
  input  logic                     clear,
  input  logic                     flag,
  input  logic                     open,
  input  logic [X_BITS-1:0]        x_pos,
  input  logic [Y_BITS-1:0]        y_pos,
  input  logic [X_BITS-1:0]        x_coord,
  input  logic [Y_BITS-1:0]        y_coord,
  output logic [1:0]               cell_val,
  output logic                     opened_cell,
  output logic [X_BITS+Y_BITS:0]   num_opened
);

  localparam int NCELLS = X_SIZE * Y_SIZE;
  localparam int IDX_W  = X_BITS + Y_BITS;
  localparam int CNT_W  = IDX_W + 1;

  localparam logic [1:0] ST_COVERED = 2'b00;
  localparam logic [1:0] ST_OPENED  = 2'b01;
  localparam logic [1:0] ST_FLAGGED = 2'b10;

  logic [1:0]       cells_q [NCELLS];
  logic [1:0]       cells_d [NCELLS];
  logic             opened_q, opened_d;
  logic [CNT_W-1:0] count_q, count_d;

  // Cursor decode
  logic             cursor_valid;
  logic [IDX_W-1:0] cursor_idx;
  logic [1:0]       cur_cell;
  logic             open_fire;
  logic             flag_fire;

  assign cursor_valid = (int'(x_pos) < X_SIZE) && (int'(y_pos) < Y_SIZE);
  assign cursor_idx   = IDX_W'(int'(y_pos) * X_SIZE + int'(x_pos));

  always_comb begin
    cur_cell = ST_COVERED;
    if (cursor_valid) begin
      cur_cell = cells_q[cursor_idx];
    end
  end

  // Only a covered cell can be opened; flagged cells are protected.
  assign open_fire = !clear && open && cursor_valid && (cur_cell == ST_COVERED);
  // Open has priority, so a simultaneous flag is dropped. Opened cells
  // ignore flag toggles.
  assign flag_fire = !clear && flag && !open && cursor_valid &&
                     ((cur_cell == ST_COVERED) || (cur_cell == ST_FLAGGED));

  // Per-cell next state
  generate
    for (genvar gi = 0; gi < NCELLS; gi++) begin : g_cell
      logic hit;
      assign hit = cursor_valid && (cursor_idx == IDX_W'(gi));
      assign cells_d[gi] = clear             ? ST_COVERED :
                           (hit && open_fire) ? ST_OPENED  :
                           (hit && flag_fire) ? ((cells_q[gi] == ST_FLAGGED) ? ST_COVERED
                                                                              : ST_FLAGGED) :
                           cells_q[gi];
    end
  endgenerate

  always_comb begin
    opened_d = open_fire;
    count_d  = count_q;
    if (clear) begin
      count_d = '0;
    end else if (open_fire && (count_q < CNT_W'(NCELLS))) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge board_clk or posedge glob_reset) begin
    if (glob_reset) begin
      for (int i = 0; i < NCELLS; i++) begin
        cells_q[i] <= ST_COVERED;
      end
      opened_q <= 1'b0;
      count_q  <= '0;
    end else begin
      cells_q  <= cells_d;
      opened_q <= opened_d;
      count_q  <= count_d;
    end
  end

  // Display read port: combinational, off-board coordinates read covered.
  logic             rd_valid;
  logic [IDX_W-1:0] rd_idx;

  assign rd_valid = (int'(x_coord) < X_SIZE) && (int'(y_coord) < Y_SIZE);
  assign rd_idx   = IDX_W'(int'(y_coord) * X_SIZE + int'(x_coord));

  always_comb begin
    cell_val = ST_COVERED;
    if (rd_valid) begin
      cell_val = cells_q[rd_idx];
    end
  end

  assign opened_cell = opened_q;
  assign num_opened  = count_q;

endmodule

// File: tb/tb_mine_cover_array.sv
// -----------------------------------------------------------------------------
// tb_mine_cover_array
//   Directed scenarios plus randomized command streams, checked against a
//   plain array model of the board's cover states.
// -----------------------------------------------------------------------------
module tb_mine_cover_array;

  logic       board_clk;
  logic       glob_reset;
  logic       clear;
  logic       flag;
  logic       open;
  logic [3:0] x_pos;
  logic [3:0] y_pos;
  logic [3:0] x_coord;
  logic [3:0] y_coord;
  logic [1:0] cell_val;
  logic       opened_cell;
  logic [8:0] num_opened;

  mine_cover_array #(
    .X_SIZE(16), .Y_SIZE(16), .X_BITS(4), .Y_BITS(4)
  ) dut (
    .board_clk  (board_clk),
    .glob_reset (glob_reset),
    .clear      (clear),
    .flag       (flag),
    .open       (open),
    .x_pos      (x_pos),
    .y_pos      (y_pos),
    .x_coord    (x_coord),
    .y_coord    (y_coord),
    .cell_val   (cell_val),
    .opened_cell(opened_cell),
    .num_opened (num_opened)
  );

  initial board_clk = 1'b0;
  always #5 board_clk = ~board_clk;

  int n_checks;
  int n_pass;

  // Reference model: cover state per cell, expected pulse and count.
  int m[256];
  bit exp_pulse;
  int exp_cnt;

  task automatic model_clear();
    for (int i = 0; i < 256; i++) m[i] = 0;
    exp_cnt   = 0;
    exp_pulse = 0;
  endtask

  task automatic model_apply(input bit c, input bit f, input bit o, input int x, input int y);
    int idx;
    exp_pulse = 0;
    if (c) begin
      model_clear();
    end else if (x < 16 && y < 16) begin
      idx = y * 16 + x;
      if (o) begin
        if (m[idx] == 0) begin
          m[idx] = 1;
          exp_pulse = 1;
          if (exp_cnt < 256) exp_cnt++;
        end
      end else if (f) begin
        if (m[idx] == 0) m[idx] = 2;
        else if (m[idx] == 2) m[idx] = 0;
      end
    end
  endtask

  // Drive one command for one clock edge; returns at the following negedge.
  task automatic step(input bit c, input bit f, input bit o, input int x, input int y);
    clear = c;
    flag  = f;
    open  = o;
    x_pos = 4'(x);
    y_pos = 4'(y);
    @(posedge board_clk);
    @(negedge board_clk);
    clear = 1'b0;
    flag  = 1'b0;
    open  = 1'b0;
    model_apply(c, f, o, x, y);
  endtask

  task automatic read_at(input int x, input int y);
    x_coord = 4'(x);
    y_coord = 4'(y);
    #1;
  endtask

  task automatic test_reset();
    int bad;
    glob_reset = 1'b1;
    repeat (2) @(negedge board_clk);
    glob_reset = 1'b0;
    model_clear();
    bad = 0;
    for (int y = 0; y < 16; y++) begin
      for (int x = 0; x < 16; x++) begin
        read_at(x, y);
        n_checks++;
        if (cell_val !== 2'b00) begin
          $display("FAIL reset_scan (%0d,%0d): got %b want 00", x, y, cell_val);
          bad++;
        end else n_pass++;
      end
    end
    n_checks++;
    if (opened_cell !== 1'b0) $display("FAIL reset_pulse: got %b want 0", opened_cell);
    else n_pass++;
    n_checks++;
    if (num_opened !== 9'd0) $display("FAIL reset_count: got %0d want 0", num_opened);
    else n_pass++;
    $display("test_reset: scanned 256 cells, %0d bad", bad);
  endtask

  task automatic test_open_basic();
    step(0, 0, 1, 3, 5);
    read_at(3, 5);
    n_checks++;
    if (cell_val !== 2'b01) $display("FAIL open35_val: got %b want 01", cell_val);
    else n_pass++;
    n_checks++;
    if (opened_cell !== 1'b1) $display("FAIL open35_pulse: got %b want 1", opened_cell);
    else n_pass++;
    n_checks++;
    if (num_opened !== 9'd1) $display("FAIL open35_count: got %0d want 1", num_opened);
    else n_pass++;
    read_at(4, 5);
    n_checks++;
    if (cell_val !== 2'b00) $display("FAIL neighbour45: got %b want 00", cell_val);
    else n_pass++;
    step(0, 0, 0, 0, 0);
    n_checks++;
    if (opened_cell !== 1'b0) $display("FAIL open35_pulse_end: got %b want 0", opened_cell);
    else n_pass++;
    $display("test_open_basic: open (3,5) cnt=%0d", num_opened);
  endtask

  task automatic test_flag_cycle();
    bit [1:0] want_val [4];
    bit       want_p   [4];
    bit       is_open  [4];
    want_val = '{2'b10, 2'b10, 2'b00, 2'b01};
    want_p   = '{1'b0, 1'b0, 1'b0, 1'b1};
    is_open  = '{1'b0, 1'b1, 1'b0, 1'b1};
    read_at(0, 0);
    for (int i = 0; i < 4; i++) begin
      step(0, !is_open[i], is_open[i], 0, 0);
      read_at(0, 0);
      n_checks++;
      if (cell_val !== want_val[i])
        $display("FAIL flag00_val[%0d]: got %b want %b", i, cell_val, want_val[i]);
      else n_pass++;
      n_checks++;
      if (opened_cell !== want_p[i])
        $display("FAIL flag00_pulse[%0d]: got %b want %b", i, opened_cell, want_p[i]);
      else n_pass++;
      $display("test_flag_cycle: %s (0,0) -> %b pulse=%b", is_open[i] ? "open" : "flag",
               cell_val, opened_cell);
    end
    n_checks++;
    if (num_opened !== 9'd2) $display("FAIL flag00_count: got %0d want 2", num_opened);
    else n_pass++;
  endtask

  task automatic test_opened_protect();
    step(0, 1, 0, 3, 5);
    read_at(3, 5);
    n_checks++;
    if (cell_val !== 2'b01) $display("FAIL flag_opened: got %b want 01", cell_val);
    else n_pass++;
    step(0, 0, 1, 3, 5);
    n_checks++;
    if (opened_cell !== 1'b0) $display("FAIL reopen_pulse: got %b want 0", opened_cell);
    else n_pass++;
    n_checks++;
    if (num_opened !== 9'd2) $display("FAIL reopen_count: got %0d want 2", num_opened);
    else n_pass++;
    $display("test_opened_protect: (3,5)=%b cnt=%0d", cell_val, num_opened);
  endtask

  task automatic test_flag_and_open_then_clear();
    int bad;
    step(0, 1, 1, 15, 15);
    read_at(15, 15);
    n_checks++;
    if (cell_val !== 2'b01) $display("FAIL fo_val: got %b want 01", cell_val);
    else n_pass++;
    n_checks++;
    if (opened_cell !== 1'b1) $display("FAIL fo_pulse: got %b want 1", opened_cell);
    else n_pass++;
    // clear together with an open: clear must dominate
    step(1, 0, 1, 7, 7);
    bad = 0;
    for (int i = 0; i < 256; i++) begin
      read_at(i % 16, i / 16);
      if (cell_val !== 2'b00) bad++;
    end
    n_checks++;
    if (bad != 0) $display("FAIL clear_scan: got %0d nonzero cells want 0", bad);
    else n_pass++;
    n_checks++;
    if (num_opened !== 9'd0) $display("FAIL clear_count: got %0d want 0", num_opened);
    else n_pass++;
    n_checks++;
    if (opened_cell !== 1'b0) $display("FAIL clear_pulse: got %b want 0", opened_cell);
    else n_pass++;
    $display("test_flag_and_open_then_clear: cnt=%0d bad=%0d", num_opened, bad);
  endtask

  task automatic test_back_to_back();
    int xs [4];
    xs = '{1, 2, 2, 3};
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 1, xs[i], 9);
      n_checks++;
      if (opened_cell !== exp_pulse)
        $display("FAIL b2b_pulse[%0d]: got %b want %b", i, opened_cell, exp_pulse);
      else n_pass++;
      n_checks++;
      if (num_opened !== 9'(exp_cnt))
        $display("FAIL b2b_count[%0d]: got %0d want %0d", i, num_opened, exp_cnt);
      else n_pass++;
      $display("test_back_to_back: open (%0d,9) pulse=%b cnt=%0d", xs[i], opened_cell, num_opened);
    end
  endtask

  task automatic test_fill_all();
    int bad;
    step(1, 0, 0, 0, 0);
    bad = 0;
    for (int i = 0; i < 256; i++) begin
      step(0, 0, 1, i % 16, i / 16);
      if (opened_cell !== 1'b1 || num_opened !== 9'(exp_cnt)) bad++;
    end
    n_checks++;
    if (bad != 0) $display("FAIL fill_steps: got %0d bad steps want 0", bad);
    else n_pass++;
    n_checks++;
    if (num_opened !== 9'd256) $display("FAIL fill_count: got %0d want 256", num_opened);
    else n_pass++;
    step(0, 0, 1, 0, 0);
    n_checks++;
    if (num_opened !== 9'd256 || opened_cell !== 1'b0)
      $display("FAIL fill_sat: got cnt=%0d pulse=%b want 256/0", num_opened, opened_cell);
    else n_pass++;
    $display("test_fill_all: cnt=%0d", num_opened);
  endtask

  task automatic test_random();
    int x, y, rx, ry, idx;
    bit c, f, o;
    step(1, 0, 0, 0, 0);
    for (int t = 0; t < 400; t++) begin
      c = ($urandom_range(0, 59) == 0);
      f = ($urandom_range(0, 2) == 0);
      o = ($urandom_range(0, 2) == 0);
      x = $urandom_range(0, 3);
      y = $urandom_range(0, 3);
      if ($urandom_range(0, 3) == 0) begin
        x = $urandom_range(0, 15);
        y = $urandom_range(0, 15);
      end
      step(c, f, o, x, y);
      idx = y * 16 + x;
      read_at(x, y);
      n_checks++;
      if (cell_val !== 2'(m[idx]))
        $display("FAIL rnd_cur[%0d] (%0d,%0d): got %b want %b", t, x, y, cell_val, 2'(m[idx]));
      else n_pass++;
      rx = $urandom_range(0, 15);
      ry = $urandom_range(0, 15);
      read_at(rx, ry);
      n_checks++;
      if (cell_val !== 2'(m[ry * 16 + rx]))
        $display("FAIL rnd_scan[%0d] (%0d,%0d): got %b want %b", t, rx, ry, cell_val,
                 2'(m[ry * 16 + rx]));
      else n_pass++;
      n_checks++;
      if (opened_cell !== exp_pulse)
        $display("FAIL rnd_pulse[%0d]: got %b want %b", t, opened_cell, exp_pulse);
      else n_pass++;
      n_checks++;
      if (num_opened !== 9'(exp_cnt))
        $display("FAIL rnd_count[%0d]: got %0d want %0d", t, num_opened, exp_cnt);
      else n_pass++;
      $display("test_random[%0d]: c=%b f=%b o=%b (%0d,%0d) val=%b pulse=%b cnt=%0d",
               t, c, f, o, x, y, 2'(m[idx]), opened_cell, num_opened);
    end
  endtask

  task automatic test_async_reset();
    step(0, 0, 1, 3, 5);
    read_at(3, 5);
    n_checks++;
    if (cell_val !== 2'(m[5 * 16 + 3]) || opened_cell !== exp_pulse)
      $display("FAIL areset_pre: got val=%b pulse=%b want %b/%b", cell_val, opened_cell,
               2'(m[5 * 16 + 3]), exp_pulse);
    else n_pass++;
    // Assert reset between edges, well away from posedge.
    #2;
    glob_reset = 1'b1;
    #1;
    n_checks++;
    if (cell_val !== 2'b00) $display("FAIL areset_val: got %b want 00", cell_val);
    else n_pass++;
    n_checks++;
    if (opened_cell !== 1'b0) $display("FAIL areset_pulse: got %b want 0", opened_cell);
    else n_pass++;
    n_checks++;
    if (num_opened !== 9'd0) $display("FAIL areset_count: got %0d want 0", num_opened);
    else n_pass++;
    @(negedge board_clk);
    glob_reset = 1'b0;
    model_clear();
    step(0, 0, 1, 3, 5);
    n_checks++;
    if (opened_cell !== 1'b1 || num_opened !== 9'd1)
      $display("FAIL areset_after: got pulse=%b cnt=%0d want 1/1", opened_cell, num_opened);
    else n_pass++;
    $display("test_async_reset: post-reset open cnt=%0d", num_opened);
  endtask

  initial begin
    n_checks   = 0;
    n_pass     = 0;
    glob_reset = 1'b1;
    clear      = 1'b0;
    flag       = 1'b0;
    open       = 1'b0;
    x_pos      = '0;
    y_pos      = '0;
    x_coord    = '0;
    y_coord    = '0;
    model_clear();

    test_reset();
    test_open_basic();
    test_flag_cycle();
    test_opened_protect();
    test_flag_and_open_then_clear();
    test_back_to_back();
    test_fill_all();
    test_random();
    test_async_reset();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
